// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// word-length codes and oversampling constants.
package uart_define;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP1  = 3'd4,
    RX_STOP2  = 3'd5
  } uart_rx_state_e;

  localparam logic [1:0] UART_WLEN_5 = 2'd0;
  localparam logic [1:0] UART_WLEN_6 = 2'd1;
  localparam logic [1:0] UART_WLEN_7 = 2'd2;
  localparam logic [1:0] UART_WLEN_8 = 2'd3;

  localparam int         UART_OVERSAMPLE = 16;
  localparam logic [3:0] UART_MID_TICK   = 4'd8;
  localparam logic [3:0] UART_LAST_TICK  = 4'(UART_OVERSAMPLE - 1);

  // Index of the final data bit for a given word-length code.
  function automatic logic [2:0] uart_last_bit(input logic [1:0] wlen);
    case (wlen)
      UART_WLEN_5: return 3'd4;
      UART_WLEN_6: return 3'd5;
      UART_WLEN_7: return 3'd6;
      default:     return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_filt.sv
// RX pin conditioning: 2-flop synchroniser, 3-sample majority filter
// advanced on the baud tick, and a falling-edge detect for start bits.
module uart_rx_filt (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic baud_tick_i,
  input  logic rx_i,
  output logic rx_filt_o,
  output logic fall_o
);

  logic       r_meta;
  logic       r_sync;
  logic       r_sync_q;
  logic [1:0] r_hist;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_q <= 1'b1;
      r_hist   <= 2'b11;
    end else begin
      r_meta   <= rx_i;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      if (baud_tick_i) r_hist <= {r_hist[0], r_sync};
    end
  end

  // Vote over the two previous tick samples and the current one.
  assign rx_filt_o = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync) | (r_hist[0] & r_sync);
  assign fall_o    = r_sync_q & ~r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART serial receive engine with a one-character valid/ready output.
// Optional idle-character timeout is built when UART_RX_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | line idle, waiting for a synchronised falling edge
// START     | validating start bit at mid-tick, glitches return to IDLE
// DATA      | shifting data bits in, LSB first
// PARITY    | checking the parity bit
// STOP1     | first stop bit; frame completes here in 1-stop mode
// STOP2     | second stop bit; frame completes here in 2-stop mode
module uart_rx_core
  import uart_define::*;
`ifdef UART_RX_TIMEOUT_EN
#(
  parameter int TIMEOUT_BITS = 40
)
`endif
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic [1:0] cfg_wlen_i,
  input  logic       cfg_pen_i,
  input  logic       cfg_eps_i,
  input  logic       cfg_stb_i,
  input  logic       rx_ready_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_perr_o,
  output logic       rx_ferr_o,
  output logic       overrun_o,
  output logic       busy_o,
  output logic       timeout_o
);

  uart_rx_state_e r_state, w_next;

  logic       w_filt, w_fall;
  logic       w_start, w_done, w_mid, w_last;
  logic [3:0] r_tick;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic [1:0] r_wlen;
  logic       r_pen, r_eps, r_stb;
  logic       r_perr, r_ferr;
  logic [1:0] w_align;
  logic [7:0] w_data;
  logic       w_par_exp;
  logic       r_valid, r_perr_o, r_ferr_o, r_ovr;
  logic [7:0] r_data;

  uart_rx_filt u_filt (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .baud_tick_i (baud_tick_i),
    .rx_i        (rx_i),
    .rx_filt_o   (w_filt),
    .fall_o      (w_fall)
  );

  assign w_mid     = baud_tick_i && (r_tick == UART_MID_TICK);
  assign w_last    = baud_tick_i && (r_tick == UART_LAST_TICK);
  assign w_align   = 2'd3 - r_wlen;
  assign w_data    = r_shift >> w_align;
  assign w_par_exp = r_eps ? (^w_data) : ~(^w_data);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= RX_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_next  = RX_START;
          w_start = 1'b1;
        end
      end
      RX_START: begin
        if (w_mid && w_filt) w_next = RX_IDLE;
        else if (w_last)     w_next = RX_DATA;
      end
      RX_DATA: begin
        if (w_last && (r_bit == uart_last_bit(r_wlen)))
          w_next = r_pen ? RX_PARITY : RX_STOP1;
      end
      RX_PARITY: begin
        if (w_last) w_next = RX_STOP1;
      end
      RX_STOP1: begin
        if (!r_stb && w_mid) begin
          w_done = 1'b1;
          w_next = RX_IDLE;
        end else if (r_stb && w_last) begin
          w_next = RX_STOP2;
        end
      end
      RX_STOP2: begin
        if (w_mid) begin
          w_done = 1'b1;
          w_next = RX_IDLE;
        end
      end
      default: w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_wlen  <= UART_WLEN_8;
      r_pen   <= 1'b0;
      r_eps   <= 1'b0;
      r_stb   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (r_state == RX_IDLE || w_next == RX_IDLE) r_tick <= '0;
      else if (baud_tick_i)                        r_tick <= r_tick + 4'd1;

      if (r_state != RX_DATA) r_bit <= '0;
      else if (w_last)        r_bit <= r_bit + 3'd1;

      if (w_start) begin
        r_shift <= '0;
        r_wlen  <= cfg_wlen_i;
        r_pen   <= cfg_pen_i;
        r_eps   <= cfg_eps_i;
        r_stb   <= cfg_stb_i;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end else begin
        if (r_state == RX_DATA && w_mid)   r_shift <= {w_filt, r_shift[7:1]};
        if (r_state == RX_PARITY && w_mid) r_perr  <= (w_filt != w_par_exp);
        if ((r_state == RX_STOP1 || r_state == RX_STOP2) && w_mid && !w_filt) r_ferr <= 1'b1;
      end
    end
  end

  // The completing stop sample is folded in directly since r_ferr lags it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ovr <= w_done && r_valid && !rx_ready_i;
      if (w_done && (!r_valid || rx_ready_i)) begin
        r_valid  <= 1'b1;
        r_data   <= w_data;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr | ~w_filt;
      end else if (r_valid && rx_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_valid_o = r_valid;
  assign rx_data_o  = r_data;
  assign rx_perr_o  = r_perr_o;
  assign rx_ferr_o  = r_ferr_o;
  assign overrun_o  = r_ovr;
  assign busy_o     = (r_state != RX_IDLE);

`ifdef UART_RX_TIMEOUT_EN
  logic        r_to_arm;
  logic [3:0]  r_to_pre;
  logic [15:0] r_to_cnt;
  logic        r_to;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_to_arm <= 1'b0;
      r_to_pre <= '0;
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else begin
      r_to <= 1'b0;
      if (w_done) begin
        r_to_arm <= 1'b1;
        r_to_pre <= '0;
        r_to_cnt <= '0;
      end else if (w_start) begin
        r_to_pre <= '0;
        r_to_cnt <= '0;
      end else if (r_to_arm && r_state == RX_IDLE && !r_valid && baud_tick_i) begin
        r_to_pre <= r_to_pre + 4'd1;
        if (r_to_pre == UART_LAST_TICK) begin
          r_to_cnt <= r_to_cnt + 16'd1;
          if (r_to_cnt == 16'(TIMEOUT_BITS - 1)) begin
            r_to     <= 1'b1;
            r_to_arm <= 1'b0;
          end
        end
      end
    end
  end

  assign timeout_o = r_to;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are built from a bit-level
// description, expected characters are queued, a monitor checks each handshake.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick = 1'b0;
  logic       rx;
  logic [1:0] cfg_wlen;
  logic       cfg_pen, cfg_eps, cfg_stb;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, overrun, busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  int to_cnt   = 0;
  int div_cnt  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_core dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .baud_tick_i (baud_tick),
    .rx_i        (rx),
    .cfg_wlen_i  (cfg_wlen),
    .cfg_pen_i   (cfg_pen),
    .cfg_eps_i   (cfg_eps),
    .cfg_stb_i   (cfg_stb),
    .rx_ready_i  (rx_ready),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .rx_perr_o   (rx_perr),
    .rx_ferr_o   (rx_ferr),
    .overrun_o   (overrun),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // 16 system clocks per baud tick
  always @(posedge clk) begin
    if (div_cnt == 15) begin
      div_cnt   <= 0;
      baud_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1;
      baud_tick <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Returns at the negedge following the n-th observed tick strobe.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!baud_tick);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] wl, input logic pen,
                            input logic eps, input logic stb, input logic bad_par,
                            input logic bad_s1, input logic bad_s2, input logic scramble,
                            input logic push);
    int         nbits;
    int         ones;
    logic [7:0] dm;
    logic       par;
    exp_t       e;
    nbits = int'(wl) + 5;
    dm    = d & (8'hFF >> (8 - nbits));
    ones  = $countones(dm);
    par   = eps ? logic'(ones % 2) : !logic'(ones % 2);
    if (push) begin
      e.d  = dm;
      e.pe = pen & bad_par;
      e.fe = bad_s1 | (stb & bad_s2);
      exp_q.push_back(e);
    end
    cfg_wlen = wl; cfg_pen = pen; cfg_eps = eps; cfg_stb = stb;
    rx = 1'b0;
    wait_ticks(16);
    if (scramble) begin
      cfg_wlen = 2'($urandom); cfg_pen = 1'($urandom);
      cfg_eps  = 1'($urandom); cfg_stb = 1'($urandom);
    end
    for (int b = 0; b < nbits; b++) begin
      rx = dm[b];
      wait_ticks(16);
    end
    if (pen) begin
      rx = par ^ bad_par;
      wait_ticks(16);
    end
    rx = ~bad_s1;
    wait_ticks(16);
    if (stb) begin
      rx = ~bad_s2;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(2);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (timeout) to_cnt++;
      if (rx_valid && rx_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_char: got data 0x%0h perr %0b ferr %0b, expected none",
                   rx_data, rx_perr, rx_ferr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({rx_data, rx_perr, rx_ferr} !== {e.d, e.pe, e.fe}) begin
            n_fail++;
            $display("FAIL char: got data 0x%0h perr %0b ferr %0b, expected data 0x%0h perr %0b ferr %0b",
                     rx_data, rx_perr, rx_ferr, e.d, e.pe, e.fe);
          end
        end
      end
    end
  end

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    cfg_wlen = 2'd3; cfg_pen = 1'b0; cfg_eps = 1'b0; cfg_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {22'd0, rx_valid, rx_data, rx_perr, rx_ferr, overrun, busy, timeout}, 32'd0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 0xA5 with completion-latency measurement in ticks from the start edge
    lat  = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5, 2'd3, 0, 0, 0, 0, 0, 0, 0, 1);
      begin
        for (int c = 0; c < 4000 && !seen; c++) begin
          @(posedge clk);
          if (baud_tick) lat++;
          @(negedge clk);
          if (rx_valid) seen = 1'b1;
        end
        check("valid_seen_8n1", 32'(seen), 32'd1);
        check("latency_ticks_8n1", 32'(lat), 32'd153);
      end
    join

    send_frame(8'h41, 2'd2, 1, 1, 0, 1, 0, 0, 0, 1);
    send_frame(8'hC3, 2'd3, 0, 0, 1, 0, 0, 1, 0, 1);

    // four-tick low glitch on idle line
    rx = 1'b0;
    wait_ticks(2);
    check("glitch_busy_rise", 32'(busy), 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(4);
    check("glitch_busy_tick7", 32'(busy), 32'd1);
    wait_ticks(1);
    check("glitch_busy_tick8", 32'(busy), 32'd0);
    wait_ticks(4);

    // overrun: second frame dropped while first is held
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    send_frame(8'h11, 2'd3, 0, 0, 0, 0, 0, 0, 0, 1);
    send_frame(8'h22, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_ticks(2);
    check("overrun_held_valid", 32'(rx_valid), 32'd1);
    check("overrun_held_data", 32'(rx_data), 32'h11);
    check("overrun_pulses", 32'(ovr_cnt), 32'd1);
    rx_ready = 1'b1;
    wait_ticks(2);

    // reset in the middle of data bit 3 of 0x5A
    rx = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 3; b++) begin
      rx = logic'((8'h5A >> b) & 8'h01);
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(8);
    check("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_frame_reset_outputs", {22'd0, rx_valid, rx_data, rx_perr, rx_ferr, overrun, busy, timeout}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);
    send_frame(8'h5A, 2'd3, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      logic [1:0] wl;
      logic       pen, eps, stb;
      d   = 8'($urandom);
      wl  = 2'($urandom_range(0, 3));
      pen = 1'($urandom);
      eps = 1'($urandom);
      stb = 1'($urandom);
      send_frame(d, wl, pen, eps, stb, pen & ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), stb & ($urandom_range(0, 3) == 0), 1, 1);
    end

`ifdef UART_RX_TIMEOUT_EN
    send_frame(8'h33, 2'd3, 0, 0, 0, 0, 0, 0, 0, 1);
    to_cnt = 0;
    wait_ticks(700);
    check("timeout_pulses", 32'(to_cnt), 32'd1);
`else
    check("timeout_tied_low", 32'(to_cnt), 32'd0);
`endif

    for (int c = 0; c < 200 && exp_q.size() > 0; c++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
